// File: rtl/parity_job_ctl.sv
// parity_job_ctl: PSL job command controller with odd-parity checking, driving a downstream parity core
module parity_job_ctl #(
    parameter int RESET_CYCLES = 4,
    parameter bit PARITY_EN = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        job_valid,
    input  logic [7:0]  job_command,
    input  logic        job_command_parity,
    input  logic [63:0] job_address,
    input  logic        job_address_parity,
    input  logic        core_done,
    input  logic        core_error,
    output logic        running,
    output logic        done,
    output logic [63:0] error,
    output logic        yield,
    output logic        core_reset,
    output logic        start_pulse,
    output logic [63:0] wed_address
);
    typedef enum logic [1:0] {IDLE, RESETTING, RUN, DONE} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  err_q, err_d;
    logic        start_q, start_d;
    logic [63:0] wed_q, wed_d;
    logic        cmd_ok, addr_ok;
    assign cmd_ok  = !PARITY_EN || (^{job_command, job_command_parity});
    assign addr_ok = !PARITY_EN || (^{job_address, job_address_parity});
    // next state: later assignments win, so job commands override core_done and countdown
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        start_d = 1'b0;
        wed_d   = wed_q;
        if (state_q == DONE) state_d = IDLE;
        if (state_q == RESETTING) begin
            if (cnt_q == 8'd0) begin
                state_d = DONE;
                err_d   = 3'd0;
            end else cnt_d = cnt_q - 8'd1;
        end
        if (state_q == RUN && core_done) begin
            state_d = DONE;
            err_d   = core_error ? 3'd4 : 3'd0;
        end
        if (job_valid) begin
            if (!cmd_ok) begin
                state_d = DONE;
                err_d   = 3'd1;
            end else if (job_command == 8'h80) begin
                state_d = RESETTING;
                cnt_d   = 8'(RESET_CYCLES - 1);
            end else if (job_command == 8'h90 && state_q == IDLE) begin
                state_d = addr_ok ? RUN : DONE;
                err_d   = addr_ok ? err_q : 3'd2;
                start_d = addr_ok;
                wed_d   = addr_ok ? job_address : wed_q;
            end
        end
    end
    // state registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            err_q   <= 3'd0;
            start_q <= 1'b0;
            wed_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            start_q <= start_d;
            wed_q   <= wed_d;
        end
    end
    assign running     = state_q == RUN;
    assign done        = state_q == DONE;
    assign core_reset  = state_q == RESETTING;
    assign error       = done ? {61'd0, err_q} : 64'd0;
    assign yield       = 1'b0;
    assign start_pulse = start_q;
    assign wed_address = wed_q;
endmodule

// File: tb/tb_parity_job_ctl.sv
// tb_parity_job_ctl: scoreboard bench for parity_job_ctl with directed job sequences
module tb_parity_job_ctl;
    logic        clock = 0;
    logic        reset = 1;
    logic        job_valid = 0, job_command_parity = 0, job_address_parity = 0;
    logic [7:0]  job_command = 0;
    logic [63:0] job_address = 0;
    logic        core_done = 0, core_error = 0;
    logic        running, done, yield, core_reset, start_pulse;
    logic [63:0] error, wed_address;
    logic        p_valid = 0, p_cpar = 0, p_apar = 0, p_done = 0;
    logic [7:0]  p_cmd = 0;
    logic [63:0] p_addr = 0;
    logic        running0, done0, yield0, core_reset0, start_pulse0;
    logic [63:0] error0, wed0;
    int checks = 0, failures = 0;
    logic [63:0] exp_err[$];
    logic [63:0] exp_wed[$];
    logic prev_done = 0, prev_start = 0;

    parity_job_ctl dut (
        .clock(clock), .reset(reset), .job_valid(job_valid), .job_command(job_command),
        .job_command_parity(job_command_parity), .job_address(job_address),
        .job_address_parity(job_address_parity), .core_done(core_done), .core_error(core_error),
        .running(running), .done(done), .error(error), .yield(yield), .core_reset(core_reset),
        .start_pulse(start_pulse), .wed_address(wed_address)
    );

    parity_job_ctl #(.RESET_CYCLES(4), .PARITY_EN(0)) dut0 (
        .clock(clock), .reset(reset), .job_valid(p_valid), .job_command(p_cmd),
        .job_command_parity(p_cpar), .job_address(p_addr), .job_address_parity(p_apar),
        .core_done(p_done), .core_error(1'b0), .running(running0), .done(done0),
        .error(error0), .yield(yield0), .core_reset(core_reset0), .start_pulse(start_pulse0),
        .wed_address(wed0)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic job(input logic [7:0] op, input logic [63:0] addr, input bit cp_good, input bit ap_good);
        job_valid = 1;
        job_command = op;
        job_command_parity = cp_good ? ~^op : ^op;
        job_address = addr;
        job_address_parity = ap_good ? ~^addr : ^addr;
        @(posedge clock);
        #1 job_valid = 0;
    endtask

    task automatic pulse_core(input bit err);
        core_done = 1;
        core_error = err;
        @(posedge clock);
        #1 core_done = 0;
        core_error = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (done) begin
            if (exp_err.size() == 0) chk("unexpected_done", {63'd0, done}, 64'd0);
            else chk("done_error", error, exp_err.pop_front());
            chk("done_single", {63'd0, prev_done}, 64'd0);
        end else chk("error_idle", error, 64'd0);
        if (start_pulse) begin
            if (exp_wed.size() == 0) chk("unexpected_start", {63'd0, start_pulse}, 64'd0);
            else chk("start_wed", wed_address, exp_wed.pop_front());
            chk("start_single", {63'd0, prev_start}, 64'd0);
        end
        chk("yield", {63'd0, yield}, 64'd0);
        prev_done = done;
        prev_start = start_pulse;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_running", {63'd0, running}, 0);
        chk("rst_done", {63'd0, done}, 0);
        chk("rst_core_reset", {63'd0, core_reset}, 0);
        chk("rst_start", {63'd0, start_pulse}, 0);
        chk("rst_wed", wed_address, 0);
        reset = 0;
        exp_wed.push_back(64'h1000);
        job(8'h90, 64'h1000, 1, 1);
        @(negedge clock);
        chk("start_running", {63'd0, running}, 1);
        @(negedge clock);
        chk("start_pulse_gone", {63'd0, start_pulse}, 0);
        job(8'h90, 64'h2000, 1, 1);
        @(negedge clock);
        chk("second_start_wed", wed_address, 64'h1000);
        chk("second_start_running", {63'd0, running}, 1);
        exp_err.push_back(64'd4);
        pulse_core(1);
        @(negedge clock);
        chk("core_err_running", {63'd0, running}, 0);
        idle(2);
        exp_wed.push_back(64'h3000);
        job(8'h90, 64'h3000, 1, 1);
        idle(1);
        exp_err.push_back(64'd0);
        pulse_core(0);
        idle(2);
        pulse_core(1);
        job(8'h42, 64'h0, 1, 1);
        job(8'h45, 64'h0, 1, 1);
        job(8'h11, 64'h0, 1, 1);
        @(negedge clock);
        chk("ignored_running", {63'd0, running}, 0);
        chk("ignored_core_reset", {63'd0, core_reset}, 0);
        exp_err.push_back(64'd0);
        job(8'h80, 64'h0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("rc_core_reset", {63'd0, core_reset}, 1);
            chk("rc_running", {63'd0, running}, 0);
            chk("rc_done", {63'd0, done}, 0);
        end
        @(negedge clock);
        chk("rc_exit_core_reset", {63'd0, core_reset}, 0);
        chk("rc_exit_done", {63'd0, done}, 1);
        chk("rc_wed_kept", wed_address, 64'h3000);
        idle(2);
        exp_err.push_back(64'd2);
        job(8'h90, 64'h5555, 1, 0);
        @(negedge clock);
        chk("addr_par_running", {63'd0, running}, 0);
        idle(2);
        exp_err.push_back(64'd1);
        job(8'h90, 64'h5555, 0, 1);
        @(negedge clock);
        chk("cmd_par_running", {63'd0, running}, 0);
        idle(2);
        exp_wed.push_back(64'h4000);
        job(8'h90, 64'h4000, 1, 1);
        idle(1);
        exp_err.push_back(64'd1);
        job(8'h80, 64'h0, 0, 1);
        @(negedge clock);
        chk("bad_reset_running", {63'd0, running}, 0);
        chk("bad_reset_core_reset", {63'd0, core_reset}, 0);
        idle(2);
        exp_wed.push_back(64'h5000);
        job(8'h90, 64'h5000, 1, 1);
        idle(1);
        exp_err.push_back(64'd0);
        core_done = 1;
        core_error = 1;
        job(8'h80, 64'h0, 1, 1);
        core_done = 0;
        core_error = 0;
        @(negedge clock);
        chk("race_core_reset", {63'd0, core_reset}, 1);
        chk("race_done", {63'd0, done}, 0);
        idle(6);
        job(8'h80, 64'h0, 1, 1);
        idle(1);
        reset = 1;
        idle(1);
        reset = 0;
        @(negedge clock);
        chk("abort_rc_core_reset", {63'd0, core_reset}, 0);
        chk("abort_rc_wed", wed_address, 0);
        exp_wed.push_back(64'h6000);
        job(8'h90, 64'h6000, 1, 1);
        idle(1);
        reset = 1;
        idle(1);
        reset = 0;
        @(negedge clock);
        chk("abort_run_running", {63'd0, running}, 0);
        exp_wed.push_back(64'h8000);
        job(8'h90, 64'h8000, 1, 1);
        @(negedge clock);
        chk("after_abort_running", {63'd0, running}, 1);
        exp_err.push_back(64'd0);
        pulse_core(0);
        idle(3);
        p_valid = 1;
        p_cmd = 8'h90;
        p_cpar = ^p_cmd;
        p_addr = 64'h7000;
        p_apar = ^p_addr;
        @(posedge clock);
        #1 p_valid = 0;
        @(negedge clock);
        chk("nopar_running", {63'd0, running0}, 1);
        chk("nopar_start", {63'd0, start_pulse0}, 1);
        chk("nopar_wed", wed0, 64'h7000);
        p_done = 1;
        @(posedge clock);
        #1 p_done = 0;
        @(negedge clock);
        chk("nopar_done", {63'd0, done0}, 1);
        chk("nopar_error", error0, 0);
        chk("nopar_running_end", {63'd0, running0}, 0);
        idle(2);
        chk("err_queue_empty", 64'(exp_err.size()), 0);
        chk("wed_queue_empty", 64'(exp_wed.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
